pe_array_controller: RTL and testbench

Sequencer that drives the controller side of the PE control interface, i.e. the row and diagonal control lines every PE in the row-stationary array consumes. It loads filter rows row-by-row, primes the ifmap scratchpads, then for each output position issues start_conv, waits for the PE psum_valid pulse, and shifts in one new ifmap value (stride 1) together with the next start. Filter and ifmap data buses run directly from upstream buffers to the PEs; this block only gates the load enables and the upstream valid/ready handshakes.

---
 rtl/pe_array_controller_if.sv | 36 +++
 rtl/pe_array_controller.sv | 171 +++++++++++++++++
 tb/tb_pe_array_controller.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_array_controller_if.sv
// Handshake and control bundle between the PE array controller, its upstream
// filter/ifmap buffers and the row-stationary PE array.
interface pe_array_controller_if #(
    parameter int unsigned NUM_ROWS  = 3,
    parameter int unsigned NUM_DIAGS = 5,
    parameter int unsigned OUT_CNT_W = 8
);
    logic                 start_i;
    logic [OUT_CNT_W-1:0] num_outputs_i;
    logic                 filter_valid_i;
    logic                 filter_ready_o;
    logic                 ifmap_valid_i;
    logic                 ifmap_ready_o;
    logic [NUM_ROWS-1:0]  read_new_filter_val_o;
    logic [NUM_DIAGS-1:0] read_new_ifmap_val_o;
    logic [NUM_DIAGS-1:0] start_conv_o;
    logic                 psum_valid_i;
    logic [OUT_CNT_W-1:0] psum_idx_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 error_o;

    // Controller side
    modport master (
        input  start_i, num_outputs_i, filter_valid_i, ifmap_valid_i, psum_valid_i,
        output filter_ready_o, ifmap_ready_o, read_new_filter_val_o,
               read_new_ifmap_val_o, start_conv_o, psum_idx_o, busy_o, done_o, error_o
    );

    // Host / buffers / PE array side
    modport slave (
        output start_i, num_outputs_i, filter_valid_i, ifmap_valid_i, psum_valid_i,
        input  filter_ready_o, ifmap_ready_o, read_new_filter_val_o,
               read_new_ifmap_val_o, start_conv_o, psum_idx_o, busy_o, done_o, error_o
    );
endinterface

// File: rtl/pe_array_controller.sv
// Sequencer for a row-stationary PE array: loads filter rows, primes ifmap
// scratchpads, then issues one start per output and checks the psum latency.
module pe_array_controller #(
    parameter int unsigned FILTER_W  = 3,
    parameter int unsigned NUM_ROWS  = 3,
    parameter int unsigned NUM_DIAGS = 5,
    parameter int unsigned OUT_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    pe_array_controller_if.master bus
);
    localparam int unsigned ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned ELEM_W   = (FILTER_W > 1) ? $clog2(FILTER_W) : 1;
    localparam int unsigned PSUM_LAT = FILTER_W + 2;
    localparam int unsigned WAIT_W   = $clog2(PSUM_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILTER,
        PRIME,
        CONV,
        SHIFT,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [OUT_CNT_W-1:0] n_q;
    logic [OUT_CNT_W-1:0] out_cnt_q;
    logic [OUT_CNT_W-1:0] psum_idx_q;
    logic [ROW_W-1:0]     row_q;
    logic [ELEM_W-1:0]    elem_q;
    logic [WAIT_W-1:0]    wait_q;
    logic                 error_q;

    logic                 filter_ready, ifmap_ready, busy, done;
    logic [NUM_ROWS-1:0]  rd_filter;
    logic [NUM_DIAGS-1:0] rd_ifmap, start_conv;
    logic                 start_ok, filter_xfer, prime_xfer, psum_ok, psum_bad;

    logic elem_last, row_last, out_last, wait_hit;
    assign elem_last = (elem_q == ELEM_W'(FILTER_W - 1));
    assign row_last  = (row_q == ROW_W'(NUM_ROWS - 1));
    assign out_last  = (out_cnt_q == n_q - OUT_CNT_W'(1));
    assign wait_hit  = (wait_q == WAIT_W'(PSUM_LAT));

    always_ff @(posedge clk_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and handshake-driven enables; everything is held off while reset is low.
    always_comb begin
        state_d      = state_q;
        filter_ready = 1'b0;
        ifmap_ready  = 1'b0;
        rd_filter    = '0;
        rd_ifmap     = '0;
        start_conv   = '0;
        busy         = 1'b0;
        done         = 1'b0;
        start_ok     = 1'b0;
        filter_xfer  = 1'b0;
        prime_xfer   = 1'b0;
        psum_ok      = 1'b0;
        psum_bad     = 1'b0;
        if (rstn_i) begin
            busy = (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        start_ok = 1'b1;
                        state_d  = (bus.num_outputs_i == '0) ? DONE : LOAD_FILTER;
                    end
                end
                LOAD_FILTER: begin
                    filter_ready = 1'b1;
                    if (bus.filter_valid_i) begin
                        filter_xfer = 1'b1;
                        rd_filter   = NUM_ROWS'(1) << row_q;
                        if (elem_last && row_last) state_d = PRIME;
                    end
                end
                PRIME: begin
                    ifmap_ready = 1'b1;
                    if (bus.ifmap_valid_i) begin
                        prime_xfer = 1'b1;
                        rd_ifmap   = '1;
                        if (elem_last) begin
                            start_conv = '1;
                            state_d    = CONV;
                        end
                    end
                end
                CONV: begin
                    // psum must land exactly PSUM_LAT cycles after start; anything else is fatal
                    if (wait_hit) begin
                        if (bus.psum_valid_i) begin
                            psum_ok = 1'b1;
                            state_d = out_last ? DONE : SHIFT;
                        end else begin
                            psum_bad = 1'b1;
                            state_d  = DONE;
                        end
                    end else if (bus.psum_valid_i) begin
                        psum_bad = 1'b1;
                        state_d  = DONE;
                    end
                end
                SHIFT: begin
                    ifmap_ready = 1'b1;
                    if (bus.ifmap_valid_i) begin
                        rd_ifmap   = '1;
                        start_conv = '1;
                        state_d    = CONV;
                    end
                end
                DONE: begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Pass counters, psum index and sticky error.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            n_q        <= '0;
            out_cnt_q  <= '0;
            psum_idx_q <= '0;
            row_q      <= '0;
            elem_q     <= '0;
            wait_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            wait_q <= (state_q == CONV) ? wait_q + WAIT_W'(1) : WAIT_W'(1);
            if (start_ok) begin
                n_q     <= bus.num_outputs_i;
                error_q <= 1'b0;
                row_q   <= '0;
                elem_q  <= '0;
            end
            if (filter_xfer || prime_xfer) begin
                if (elem_last) begin
                    elem_q <= '0;
                    if (filter_xfer) row_q <= row_q + ROW_W'(1);
                end else begin
                    elem_q <= elem_q + ELEM_W'(1);
                end
            end
            if (prime_xfer && elem_last) out_cnt_q <= '0;
            if (psum_ok) begin
                psum_idx_q <= out_cnt_q;
                if (!out_last) out_cnt_q <= out_cnt_q + OUT_CNT_W'(1);
            end
            if (psum_bad) error_q <= 1'b1;
        end
    end

    assign bus.filter_ready_o        = filter_ready;
    assign bus.ifmap_ready_o         = ifmap_ready;
    assign bus.read_new_filter_val_o = rd_filter;
    assign bus.read_new_ifmap_val_o  = rd_ifmap;
    assign bus.start_conv_o          = start_conv;
    assign bus.psum_idx_o            = psum_idx_q;
    assign bus.busy_o                = busy;
    assign bus.done_o                = done;
    assign bus.error_o               = error_q;
endmodule

// File: tb/tb_pe_array_controller.sv
// Randomized scoreboard bench for pe_array_controller: expected enable/psum/done
// event streams are generated per pass and popped by an independent monitor.
module tb_pe_array_controller;
    localparam int unsigned FILTER_W  = 3;
    localparam int unsigned NUM_ROWS  = 3;
    localparam int unsigned NUM_DIAGS = 5;
    localparam int unsigned OUT_CNT_W = 8;

    localparam int EV_FILT = 0;
    localparam int EV_IFM  = 1;
    localparam int EV_PSUM = 2;
    localparam int EV_DONE = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic clk_i = 1'b0;
    logic rstn_i = 1'b0;
    int   cyc = 0;

    pe_array_controller_if #(
        .NUM_ROWS (NUM_ROWS),
        .NUM_DIAGS(NUM_DIAGS),
        .OUT_CNT_W(OUT_CNT_W)
    ) bus ();

    pe_array_controller #(
        .FILTER_W (FILTER_W),
        .NUM_ROWS (NUM_ROWS),
        .NUM_DIAGS(NUM_DIAGS),
        .OUT_CNT_W(OUT_CNT_W)
    ) dut (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  pe_delay[$];
    int  total = 0;
    int  bad = 0;
    int  fv_mode = 0;
    int  iv_mode = 0;
    int  resp_cyc = -1;
    int  n_starts = 0;
    int  last_start_cyc = 0;
    int  start_cyc = 0;
    int  done_cyc = 0;
    bit  saw_ready = 0;
    bit  psum_prev = 0;

    function automatic int ifm_code(input bit st);
        int ones;
        ones = (1 << NUM_DIAGS) - 1;
        return (ones << NUM_DIAGS) | (st ? ones : 0);
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_FILT: return "filter_en";
            EV_IFM:  return "ifmap_en";
            EV_PSUM: return "psum_idx";
            default: return "done";
        endcase
    endfunction

    // Reference trace of a pass: what the array should see, independent of stalls.
    task automatic push_expected(input int n, input int fail_at);
        ev_t e;
        if (n > 0) begin
            for (int r = 0; r < int'(NUM_ROWS); r++)
                for (int k = 0; k < int'(FILTER_W); k++) begin
                    e.kind = EV_FILT; e.val = 1 << r; exp_q.push_back(e);
                end
            for (int p = 0; p < int'(FILTER_W); p++) begin
                e.kind = EV_IFM; e.val = ifm_code(p == int'(FILTER_W) - 1); exp_q.push_back(e);
            end
            for (int k = 0; k < n; k++) begin
                if (k == fail_at) begin
                    e.kind = EV_DONE; e.val = 1; exp_q.push_back(e);
                    return;
                end
                e.kind = EV_PSUM; e.val = k; exp_q.push_back(e);
                if (k < n - 1) begin
                    e.kind = EV_IFM; e.val = ifm_code(1'b1); exp_q.push_back(e);
                end
            end
        end
        e.kind = EV_DONE; e.val = 0; exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s at cycle %0d: got %0h, required no event", kname(kind), cyc, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                bad++;
                $display("FAIL %s at cycle %0d: got %s=%0h, required %s=%0h",
                         kname(e.kind), cyc, kname(kind), val, kname(e.kind), e.val);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Upstream buffers and PE model, driven just after the active edge.
    always @(posedge clk_i) begin
        #1;
        case (fv_mode)
            0:       bus.filter_valid_i = 1'b1;
            1:       bus.filter_valid_i = (cyc % 2 == 0);
            default: bus.filter_valid_i = 1'($urandom_range(0, 1));
        endcase
        case (iv_mode)
            0:       bus.ifmap_valid_i = 1'b1;
            1:       bus.ifmap_valid_i = (cyc % 2 == 0);
            default: bus.ifmap_valid_i = 1'($urandom_range(0, 1));
        endcase
        bus.psum_valid_i = (resp_cyc >= 0 && cyc == resp_cyc);
    end

    // Monitor: turns observed outputs into events and compares against the scoreboard.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (bus.filter_ready_o || bus.ifmap_ready_o) saw_ready = 1'b1;
            if (psum_prev && !bus.error_o) check_ev(EV_PSUM, int'(bus.psum_idx_o));
            if (bus.done_o) check_ev(EV_DONE, int'(bus.error_o));
            if (bus.read_new_filter_val_o != '0) check_ev(EV_FILT, int'(bus.read_new_filter_val_o));
            if (bus.read_new_ifmap_val_o != '0 || bus.start_conv_o != '0) begin
                check_ev(EV_IFM, int'({bus.read_new_ifmap_val_o, bus.start_conv_o}));
                if (bus.start_conv_o != '0) begin
                    int d;
                    d = (n_starts < pe_delay.size()) ? pe_delay[n_starts] : int'(FILTER_W) + 2;
                    resp_cyc = (d == 0) ? -1 : cyc + d;
                    last_start_cyc = cyc;
                    n_starts++;
                end
            end
        end
        psum_prev = bus.psum_valid_i;
    end

    task automatic run_start(input int n, input int fail_at);
        @(posedge clk_i); #1;
        bus.start_i       = 1'b1;
        bus.num_outputs_i = OUT_CNT_W'(n);
        start_cyc = cyc;
        n_starts  = 0;
        saw_ready = 1'b0;
        push_expected(n, fail_at);
        @(posedge clk_i); #1;
        bus.start_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk_i); #1;
            if (bus.done_o) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: done_o never seen, required a done pulse", name);
        end else begin
            @(negedge clk_i); #1;
            check({name, " busy after done"}, int'(bus.busy_o), 0);
            check({name, " trace drained"}, exp_q.size(), 0);
        end
        exp_q.delete();
        resp_cyc = -1;
    endtask

    function automatic int all_outs();
        return int'(bus.filter_ready_o) + int'(bus.ifmap_ready_o) + int'(bus.read_new_filter_val_o)
             + int'(bus.read_new_ifmap_val_o) + int'(bus.start_conv_o) + int'(bus.psum_idx_o)
             + int'(bus.busy_o) + int'(bus.done_o) + int'(bus.error_o);
    endfunction

    initial begin
        bus.start_i        = 1'b0;
        bus.num_outputs_i  = '0;
        bus.filter_valid_i = 1'b0;
        bus.ifmap_valid_i  = 1'b0;
        bus.psum_valid_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        check("reset outputs", all_outs(), 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        // Nominal pass, then filter upstream stalling every other cycle
        run_start(3, -1);
        wait_done("nominal N=3");
        fv_mode = 1;
        run_start(3, -1);
        wait_done("filter stall N=3");
        fv_mode = 0;

        // PE answers one cycle early on the second output
        pe_delay = '{5, 4};
        run_start(3, 1);
        wait_done("early psum");
        check("early done timing", done_cyc, last_start_cyc + 5);
        check("error sticky", int'(bus.error_o), 1);
        pe_delay = {};

        // PE never answers; the next start must also clear error_o
        pe_delay = '{0};
        run_start(2, 0);
        @(negedge clk_i); #1;
        check("error cleared by start", int'(bus.error_o), 0);
        wait_done("no psum");
        check("timeout done timing", done_cyc, last_start_cyc + int'(FILTER_W) + 3);
        check("timeout error", int'(bus.error_o), 1);
        pe_delay = {};

        // Empty pass
        run_start(0, -1);
        wait_done("N=0");
        check("N=0 done latency", done_cyc, start_cyc + 1);
        check("N=0 readies", int'(saw_ready), 0);

        // Reset during CONV of output 1, then a clean single-output pass
        run_start(3, -1);
        for (int k = 0; k < 500 && n_starts < 2; k++) @(posedge clk_i);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b0;
        exp_q.delete();
        resp_cyc = -1;
        @(negedge clk_i); #1;
        check("mid-pass reset outputs", all_outs() - int'(bus.psum_idx_o) - int'(bus.error_o), 0);
        @(negedge clk_i); #1;
        check("reset outputs after edge", all_outs(), 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        run_start(1, -1);
        wait_done("after reset N=1");
        check("final psum_idx", int'(bus.psum_idx_o), 0);

        // Random passes with random upstream stalls
        for (int it = 0; it < 5; it++) begin
            fv_mode = $urandom_range(0, 2);
            iv_mode = $urandom_range(0, 2);
            run_start($urandom_range(1, 6), -1);
            wait_done("random pass");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
